// File: rtl/ram_window_guard_pkg.sv
// Shared types and constants for ram_window_guard.
//   RESP_OKAY / RESP_DECERR : AXI response codes used by the guard
//   wr_state_e              : write-side FSM states (idle, drain W, local B)
//   rd_state_e              : read-side FSM states (idle, local error R burst)
package ram_window_guard_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_DRAIN = 2'd1,
        WR_RESP  = 2'd2
    } wr_state_e;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_ERR  = 1'b1
    } rd_state_e;

endpackage

// File: rtl/ram_window_guard_cnt.sv
// Up/down outstanding-transaction counter.
//   clk, rst : clock, synchronous active-high reset
//   inc, dec : count one request issued / one response completed
//   cnt      : current count
//   full     : cnt == MAX (no more requests may be issued)
//   zero     : cnt == 0 (nothing in flight downstream)
// An increment while full or a decrement while zero is ignored; the
// parent never issues either, the check only keeps the count in range.
module ram_window_guard_cnt #(
    parameter int unsigned MAX = 8,
    parameter int unsigned CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          full,
    output logic          zero
);

    logic [CW-1:0] cnt_q, cnt_d;

    assign cnt  = cnt_q;
    assign full = (cnt_q == CW'(MAX));
    assign zero = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        // Simultaneous inc and dec cancel out.
        if (inc && !dec && !full) begin
            cnt_d = cnt_q + CW'(1);
        end else if (dec && !inc && !zero) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ram_window_guard.sv
// AXI4 guard in front of the RAM offset wrapper.
// Transactions whose start address lies in [BASE, BASE+SIZE) pass through
// combinationally and are counted while outstanding. Transactions outside
// the window are terminated locally with DECERR: W beats are absorbed and a
// B is generated; reads return arlen+1 zero-data beats.
//   aclk, areset          : clock, synchronous active-high reset
//   wr_busy / rd_busy     : FSM not idle or transactions outstanding
//   s_axi_ram_*           : slave side (from crossbar), full AXI4
//   m_axi_ram_*           : master side (to offset wrapper), full AXI4
//   dbg_*                 : FSM states and outstanding counts for observation
// Handshakes: a beat transfers on a rising edge where valid & ready are both
// high; a valid, once raised, holds with stable payload until that transfer.
module ram_window_guard
    import ram_window_guard_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned AXI_DATA_WIDTH  = 64,
    parameter int unsigned AXI_ID_WIDTH    = 5,
    parameter int unsigned AXI_USER_WIDTH  = 1,
    parameter logic [63:0] BASE            = 64'h8000_0000,
    parameter logic [63:0] SIZE            = 64'h4000_0000,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                          aclk,
    input  logic                          areset,
    output logic                          wr_busy,
    output logic                          rd_busy,
    output wr_state_e                     dbg_wr_state,
    output rd_state_e                     dbg_rd_state,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] dbg_wcnt,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] dbg_rcnt,
    // slave AW
    input  logic [AXI_ID_WIDTH-1:0]       s_axi_ram_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_ram_awaddr,
    input  logic [7:0]                    s_axi_ram_awlen,
    input  logic [2:0]                    s_axi_ram_awsize,
    input  logic [1:0]                    s_axi_ram_awburst,
    input  logic                          s_axi_ram_awlock,
    input  logic [3:0]                    s_axi_ram_awcache,
    input  logic [2:0]                    s_axi_ram_awprot,
    input  logic [3:0]                    s_axi_ram_awqos,
    input  logic [3:0]                    s_axi_ram_awregion,
    input  logic [5:0]                    s_axi_ram_awatop,
    input  logic [AXI_USER_WIDTH-1:0]     s_axi_ram_awuser,
    input  logic                          s_axi_ram_awvalid,
    output logic                          s_axi_ram_awready,
    // slave W
    input  logic [AXI_DATA_WIDTH-1:0]     s_axi_ram_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_ram_wstrb,
    input  logic                          s_axi_ram_wlast,
    input  logic [AXI_USER_WIDTH-1:0]     s_axi_ram_wuser,
    input  logic                          s_axi_ram_wvalid,
    output logic                          s_axi_ram_wready,
    // slave B
    output logic [AXI_ID_WIDTH-1:0]       s_axi_ram_bid,
    output logic [1:0]                    s_axi_ram_bresp,
    output logic [AXI_USER_WIDTH-1:0]     s_axi_ram_buser,
    output logic                          s_axi_ram_bvalid,
    input  logic                          s_axi_ram_bready,
    // slave AR
    input  logic [AXI_ID_WIDTH-1:0]       s_axi_ram_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_ram_araddr,
    input  logic [7:0]                    s_axi_ram_arlen,
    input  logic [2:0]                    s_axi_ram_arsize,
    input  logic [1:0]                    s_axi_ram_arburst,
    input  logic                          s_axi_ram_arlock,
    input  logic [3:0]                    s_axi_ram_arcache,
    input  logic [2:0]                    s_axi_ram_arprot,
    input  logic [3:0]                    s_axi_ram_arqos,
    input  logic [3:0]                    s_axi_ram_arregion,
    input  logic [AXI_USER_WIDTH-1:0]     s_axi_ram_aruser,
    input  logic                          s_axi_ram_arvalid,
    output logic                          s_axi_ram_arready,
    // slave R
    output logic [AXI_ID_WIDTH-1:0]       s_axi_ram_rid,
    output logic [AXI_DATA_WIDTH-1:0]     s_axi_ram_rdata,
    output logic [1:0]                    s_axi_ram_rresp,
    output logic                          s_axi_ram_rlast,
    output logic [AXI_USER_WIDTH-1:0]     s_axi_ram_ruser,
    output logic                          s_axi_ram_rvalid,
    input  logic                          s_axi_ram_rready,
    // master AW
    output logic [AXI_ID_WIDTH-1:0]       m_axi_ram_awid,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_ram_awaddr,
    output logic [7:0]                    m_axi_ram_awlen,
    output logic [2:0]                    m_axi_ram_awsize,
    output logic [1:0]                    m_axi_ram_awburst,
    output logic                          m_axi_ram_awlock,
    output logic [3:0]                    m_axi_ram_awcache,
    output logic [2:0]                    m_axi_ram_awprot,
    output logic [3:0]                    m_axi_ram_awqos,
    output logic [3:0]                    m_axi_ram_awregion,
    output logic [5:0]                    m_axi_ram_awatop,
    output logic [AXI_USER_WIDTH-1:0]     m_axi_ram_awuser,
    output logic                          m_axi_ram_awvalid,
    input  logic                          m_axi_ram_awready,
    // master W
    output logic [AXI_DATA_WIDTH-1:0]     m_axi_ram_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_ram_wstrb,
    output logic                          m_axi_ram_wlast,
    output logic [AXI_USER_WIDTH-1:0]     m_axi_ram_wuser,
    output logic                          m_axi_ram_wvalid,
    input  logic                          m_axi_ram_wready,
    // master B
    input  logic [AXI_ID_WIDTH-1:0]       m_axi_ram_bid,
    input  logic [1:0]                    m_axi_ram_bresp,
    input  logic [AXI_USER_WIDTH-1:0]     m_axi_ram_buser,
    input  logic                          m_axi_ram_bvalid,
    output logic                          m_axi_ram_bready,
    // master AR
    output logic [AXI_ID_WIDTH-1:0]       m_axi_ram_arid,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_ram_araddr,
    output logic [7:0]                    m_axi_ram_arlen,
    output logic [2:0]                    m_axi_ram_arsize,
    output logic [1:0]                    m_axi_ram_arburst,
    output logic                          m_axi_ram_arlock,
    output logic [3:0]                    m_axi_ram_arcache,
    output logic [2:0]                    m_axi_ram_arprot,
    output logic [3:0]                    m_axi_ram_arqos,
    output logic [3:0]                    m_axi_ram_arregion,
    output logic [AXI_USER_WIDTH-1:0]     m_axi_ram_aruser,
    output logic                          m_axi_ram_arvalid,
    input  logic                          m_axi_ram_arready,
    // master R
    input  logic [AXI_ID_WIDTH-1:0]       m_axi_ram_rid,
    input  logic [AXI_DATA_WIDTH-1:0]     m_axi_ram_rdata,
    input  logic [1:0]                    m_axi_ram_rresp,
    input  logic                          m_axi_ram_rlast,
    input  logic [AXI_USER_WIDTH-1:0]     m_axi_ram_ruser,
    input  logic                          m_axi_ram_rvalid,
    output logic                          m_axi_ram_rready
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // Window bounds carry one extra bit so BASE+SIZE == 2^AXI_ADDR_WIDTH works.
    localparam logic [63:0]             WIN_END = BASE + SIZE;
    localparam logic [AXI_ADDR_WIDTH:0] WIN_LO  = BASE[AXI_ADDR_WIDTH:0];
    localparam logic [AXI_ADDR_WIDTH:0] WIN_HI  = WIN_END[AXI_ADDR_WIDTH:0];

    wr_state_e                   wr_state_q, wr_state_d;
    rd_state_e                   rd_state_q, rd_state_d;
    logic [AXI_ID_WIDTH-1:0]     wid_q, wid_d, rid_q, rid_d;
    logic [7:0]                  rlen_q, rlen_d, beat_q, beat_d;

    logic aw_in_range, ar_in_range;
    logic wr_idle, rd_idle, wr_stall, rd_stall;
    logic wfull, wzero, rfull, rzero;
    logic aw_local_hs, ar_local_hs;

    assign aw_in_range = ({1'b0, s_axi_ram_awaddr} >= WIN_LO) && ({1'b0, s_axi_ram_awaddr} < WIN_HI);
    assign ar_in_range = ({1'b0, s_axi_ram_araddr} >= WIN_LO) && ({1'b0, s_axi_ram_araddr} < WIN_HI);

    assign wr_idle  = (wr_state_q == WR_IDLE);
    assign rd_idle  = (rd_state_q == RD_IDLE);
    assign wr_stall = !wr_idle || wfull;
    assign rd_stall = !rd_idle || rfull;

    // Local termination waits until nothing is in flight downstream, so the
    // locally generated response can never overtake an earlier RAM response.
    assign aw_local_hs = s_axi_ram_awvalid && !aw_in_range && wr_idle && wzero;
    assign ar_local_hs = s_axi_ram_arvalid && !ar_in_range && rd_idle && rzero;

    // Address channels.
    assign m_axi_ram_awvalid = s_axi_ram_awvalid && aw_in_range && !wr_stall;
    assign s_axi_ram_awready = aw_in_range ? (m_axi_ram_awready && !wr_stall) : (wr_idle && wzero);
    assign m_axi_ram_arvalid = s_axi_ram_arvalid && ar_in_range && !rd_stall;
    assign s_axi_ram_arready = ar_in_range ? (m_axi_ram_arready && !rd_stall) : (rd_idle && rzero);

    assign m_axi_ram_awid     = s_axi_ram_awid;
    assign m_axi_ram_awaddr   = s_axi_ram_awaddr;
    assign m_axi_ram_awlen    = s_axi_ram_awlen;
    assign m_axi_ram_awsize   = s_axi_ram_awsize;
    assign m_axi_ram_awburst  = s_axi_ram_awburst;
    assign m_axi_ram_awlock   = s_axi_ram_awlock;
    assign m_axi_ram_awcache  = s_axi_ram_awcache;
    assign m_axi_ram_awprot   = s_axi_ram_awprot;
    assign m_axi_ram_awqos    = s_axi_ram_awqos;
    assign m_axi_ram_awregion = s_axi_ram_awregion;
    assign m_axi_ram_awatop   = s_axi_ram_awatop;
    assign m_axi_ram_awuser   = s_axi_ram_awuser;
    assign m_axi_ram_arid     = s_axi_ram_arid;
    assign m_axi_ram_araddr   = s_axi_ram_araddr;
    assign m_axi_ram_arlen    = s_axi_ram_arlen;
    assign m_axi_ram_arsize   = s_axi_ram_arsize;
    assign m_axi_ram_arburst  = s_axi_ram_arburst;
    assign m_axi_ram_arlock   = s_axi_ram_arlock;
    assign m_axi_ram_arcache  = s_axi_ram_arcache;
    assign m_axi_ram_arprot   = s_axi_ram_arprot;
    assign m_axi_ram_arqos    = s_axi_ram_arqos;
    assign m_axi_ram_arregion = s_axi_ram_arregion;
    assign m_axi_ram_aruser   = s_axi_ram_aruser;
    assign m_axi_ram_wdata    = s_axi_ram_wdata;
    assign m_axi_ram_wstrb    = s_axi_ram_wstrb;
    assign m_axi_ram_wlast    = s_axi_ram_wlast;
    assign m_axi_ram_wuser    = s_axi_ram_wuser;

    ram_window_guard_cnt #(.MAX(MAX_OUTSTANDING), .CW(CNT_W)) u_wcnt (
        .clk (aclk),
        .rst (areset),
        .inc (m_axi_ram_awvalid && m_axi_ram_awready),
        .dec (m_axi_ram_bvalid && m_axi_ram_bready),
        .cnt (dbg_wcnt),
        .full(wfull),
        .zero(wzero)
    );

    ram_window_guard_cnt #(.MAX(MAX_OUTSTANDING), .CW(CNT_W)) u_rcnt (
        .clk (aclk),
        .rst (areset),
        .inc (m_axi_ram_arvalid && m_axi_ram_arready),
        .dec (m_axi_ram_rvalid && m_axi_ram_rready && m_axi_ram_rlast),
        .cnt (dbg_rcnt),
        .full(rfull),
        .zero(rzero)
    );

    // Write FSM next state.
    always_comb begin
        wr_state_d = wr_state_q;
        wid_d      = wid_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_local_hs) begin
                    wr_state_d = WR_DRAIN;
                    wid_d      = s_axi_ram_awid;
                end
            end
            WR_DRAIN: if (s_axi_ram_wvalid && s_axi_ram_wlast) wr_state_d = WR_RESP;
            WR_RESP:  if (s_axi_ram_bready) wr_state_d = WR_IDLE;
            default:  wr_state_d = WR_IDLE;
        endcase
    end

    // W/B steering: pass-through when idle, local drain/response otherwise.
    always_comb begin
        s_axi_ram_wready = m_axi_ram_wready;
        m_axi_ram_wvalid = s_axi_ram_wvalid;
        m_axi_ram_bready = s_axi_ram_bready;
        s_axi_ram_bvalid = m_axi_ram_bvalid;
        s_axi_ram_bid    = m_axi_ram_bid;
        s_axi_ram_bresp  = m_axi_ram_bresp;
        s_axi_ram_buser  = m_axi_ram_buser;
        if (!wr_idle) begin
            m_axi_ram_wvalid = 1'b0;
            m_axi_ram_bready = 1'b0;
            s_axi_ram_wready = (wr_state_q == WR_DRAIN);
            s_axi_ram_bvalid = (wr_state_q == WR_RESP);
            s_axi_ram_bid    = wid_q;
            s_axi_ram_bresp  = RESP_DECERR;
            s_axi_ram_buser  = '0;
        end
    end

    // Read FSM next state.
    always_comb begin
        rd_state_d = rd_state_q;
        rid_d      = rid_q;
        rlen_d     = rlen_q;
        beat_d     = beat_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (ar_local_hs) begin
                    rd_state_d = RD_ERR;
                    rid_d      = s_axi_ram_arid;
                    rlen_d     = s_axi_ram_arlen;
                    beat_d     = '0;
                end
            end
            RD_ERR: begin
                if (s_axi_ram_rready) begin
                    if (beat_q == rlen_q) rd_state_d = RD_IDLE;
                    else                  beat_d     = beat_q + 8'd1;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        m_axi_ram_rready = s_axi_ram_rready;
        s_axi_ram_rvalid = m_axi_ram_rvalid;
        s_axi_ram_rid    = m_axi_ram_rid;
        s_axi_ram_rdata  = m_axi_ram_rdata;
        s_axi_ram_rresp  = m_axi_ram_rresp;
        s_axi_ram_rlast  = m_axi_ram_rlast;
        s_axi_ram_ruser  = m_axi_ram_ruser;
        if (!rd_idle) begin
            m_axi_ram_rready = 1'b0;
            s_axi_ram_rvalid = 1'b1;
            s_axi_ram_rid    = rid_q;
            s_axi_ram_rdata  = '0;
            s_axi_ram_rresp  = RESP_DECERR;
            s_axi_ram_rlast  = (beat_q == rlen_q);
            s_axi_ram_ruser  = '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            wid_q      <= '0;
            rid_q      <= '0;
            rlen_q     <= '0;
            beat_q     <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wid_q      <= wid_d;
            rid_q      <= rid_d;
            rlen_q     <= rlen_d;
            beat_q     <= beat_d;
        end
    end

    assign wr_busy      = !wr_idle || !wzero;
    assign rd_busy      = !rd_idle || !rzero;
    assign dbg_wr_state = wr_state_q;
    assign dbg_rd_state = rd_state_q;

endmodule

// File: tb/tb_ram_window_guard.sv
module tb_ram_window_guard;
    import ram_window_guard_pkg::*;

    localparam int AW = 32, DW = 64, IW = 5, UW = 1, MAXO = 2;

    logic aclk = 1'b0, areset = 1'b1;
    logic wr_busy, rd_busy;
    wr_state_e dbg_wr_state;
    rd_state_e dbg_rd_state;
    logic [1:0] dbg_wcnt, dbg_rcnt;

    logic [IW-1:0] s_awid, s_arid, s_bid, s_rid, m_awid, m_arid, m_bid, m_rid;
    logic [AW-1:0] s_awaddr, s_araddr, m_awaddr, m_araddr;
    logic [7:0] s_awlen, s_arlen, m_awlen, m_arlen;
    logic [2:0] s_awsize, s_arsize, m_awsize, m_arsize, s_awprot, s_arprot, m_awprot, m_arprot;
    logic [1:0] s_awburst, s_arburst, m_awburst, m_arburst, s_bresp, s_rresp, m_bresp, m_rresp;
    logic s_awlock, s_arlock, m_awlock, m_arlock;
    logic [3:0] s_awcache, s_arcache, m_awcache, m_arcache, s_awqos, s_arqos, m_awqos, m_arqos;
    logic [3:0] s_awregion, s_arregion, m_awregion, m_arregion;
    logic [5:0] s_awatop, m_awatop;
    logic [UW-1:0] s_awuser, s_aruser, s_wuser, s_buser, s_ruser;
    logic [UW-1:0] m_awuser, m_aruser, m_wuser, m_buser, m_ruser;
    logic s_awvalid, s_awready, s_arvalid, s_arready, m_awvalid, m_awready, m_arvalid, m_arready;
    logic [DW-1:0] s_wdata, m_wdata, s_rdata, m_rdata;
    logic [DW/8-1:0] s_wstrb, m_wstrb;
    logic s_wlast, m_wlast, s_wvalid, s_wready, m_wvalid, m_wready;
    logic s_bvalid, s_bready, m_bvalid, m_bready;
    logic s_rlast, m_rlast, s_rvalid, s_rready, m_rvalid, m_rready;

    int n_checks = 0;
    int n_pass   = 0;
    int beats;
    logic exp_q[$];

    always #5 aclk = ~aclk;

    ram_window_guard #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW),
        .BASE(64'h8000_0000), .SIZE(64'h4000_0000), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .aclk(aclk), .areset(areset), .wr_busy(wr_busy), .rd_busy(rd_busy),
        .dbg_wr_state(dbg_wr_state), .dbg_rd_state(dbg_rd_state),
        .dbg_wcnt(dbg_wcnt), .dbg_rcnt(dbg_rcnt),
        .s_axi_ram_awid(s_awid), .s_axi_ram_awaddr(s_awaddr), .s_axi_ram_awlen(s_awlen),
        .s_axi_ram_awsize(s_awsize), .s_axi_ram_awburst(s_awburst), .s_axi_ram_awlock(s_awlock),
        .s_axi_ram_awcache(s_awcache), .s_axi_ram_awprot(s_awprot), .s_axi_ram_awqos(s_awqos),
        .s_axi_ram_awregion(s_awregion), .s_axi_ram_awatop(s_awatop), .s_axi_ram_awuser(s_awuser),
        .s_axi_ram_awvalid(s_awvalid), .s_axi_ram_awready(s_awready),
        .s_axi_ram_wdata(s_wdata), .s_axi_ram_wstrb(s_wstrb), .s_axi_ram_wlast(s_wlast),
        .s_axi_ram_wuser(s_wuser), .s_axi_ram_wvalid(s_wvalid), .s_axi_ram_wready(s_wready),
        .s_axi_ram_bid(s_bid), .s_axi_ram_bresp(s_bresp), .s_axi_ram_buser(s_buser),
        .s_axi_ram_bvalid(s_bvalid), .s_axi_ram_bready(s_bready),
        .s_axi_ram_arid(s_arid), .s_axi_ram_araddr(s_araddr), .s_axi_ram_arlen(s_arlen),
        .s_axi_ram_arsize(s_arsize), .s_axi_ram_arburst(s_arburst), .s_axi_ram_arlock(s_arlock),
        .s_axi_ram_arcache(s_arcache), .s_axi_ram_arprot(s_arprot), .s_axi_ram_arqos(s_arqos),
        .s_axi_ram_arregion(s_arregion), .s_axi_ram_aruser(s_aruser),
        .s_axi_ram_arvalid(s_arvalid), .s_axi_ram_arready(s_arready),
        .s_axi_ram_rid(s_rid), .s_axi_ram_rdata(s_rdata), .s_axi_ram_rresp(s_rresp),
        .s_axi_ram_rlast(s_rlast), .s_axi_ram_ruser(s_ruser), .s_axi_ram_rvalid(s_rvalid),
        .s_axi_ram_rready(s_rready),
        .m_axi_ram_awid(m_awid), .m_axi_ram_awaddr(m_awaddr), .m_axi_ram_awlen(m_awlen),
        .m_axi_ram_awsize(m_awsize), .m_axi_ram_awburst(m_awburst), .m_axi_ram_awlock(m_awlock),
        .m_axi_ram_awcache(m_awcache), .m_axi_ram_awprot(m_awprot), .m_axi_ram_awqos(m_awqos),
        .m_axi_ram_awregion(m_awregion), .m_axi_ram_awatop(m_awatop), .m_axi_ram_awuser(m_awuser),
        .m_axi_ram_awvalid(m_awvalid), .m_axi_ram_awready(m_awready),
        .m_axi_ram_wdata(m_wdata), .m_axi_ram_wstrb(m_wstrb), .m_axi_ram_wlast(m_wlast),
        .m_axi_ram_wuser(m_wuser), .m_axi_ram_wvalid(m_wvalid), .m_axi_ram_wready(m_wready),
        .m_axi_ram_bid(m_bid), .m_axi_ram_bresp(m_bresp), .m_axi_ram_buser(m_buser),
        .m_axi_ram_bvalid(m_bvalid), .m_axi_ram_bready(m_bready),
        .m_axi_ram_arid(m_arid), .m_axi_ram_araddr(m_araddr), .m_axi_ram_arlen(m_arlen),
        .m_axi_ram_arsize(m_arsize), .m_axi_ram_arburst(m_arburst), .m_axi_ram_arlock(m_arlock),
        .m_axi_ram_arcache(m_arcache), .m_axi_ram_arprot(m_arprot), .m_axi_ram_arqos(m_arqos),
        .m_axi_ram_arregion(m_arregion), .m_axi_ram_aruser(m_aruser),
        .m_axi_ram_arvalid(m_arvalid), .m_axi_ram_arready(m_arready),
        .m_axi_ram_rid(m_rid), .m_axi_ram_rdata(m_rdata), .m_axi_ram_rresp(m_rresp),
        .m_axi_ram_rlast(m_rlast), .m_axi_ram_ruser(m_ruser), .m_axi_ram_rvalid(m_rvalid),
        .m_axi_ram_rready(m_rready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_aw(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IW-1:0] id);
        s_awvalid = 1'b1; s_awaddr = addr; s_awlen = len; s_awid = id;
    endtask

    task automatic drive_ar(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IW-1:0] id);
        s_arvalid = 1'b1; s_araddr = addr; s_arlen = len; s_arid = id;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = 3'd3; s_awburst = 2'b01; s_awlock = 1'b0;
        s_awcache = '0; s_awprot = '0; s_awqos = '0; s_awregion = '0; s_awatop = '0; s_awuser = '0;
        s_awvalid = 1'b0;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = 3'd3; s_arburst = 2'b01; s_arlock = 1'b0;
        s_arcache = '0; s_arprot = '0; s_arqos = '0; s_arregion = '0; s_aruser = '0; s_arvalid = 1'b0;
        s_wdata = '0; s_wstrb = '1; s_wlast = 1'b0; s_wuser = '0; s_wvalid = 1'b0;
        s_bready = 1'b1; s_rready = 1'b0;
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
        m_bid = '0; m_bresp = '0; m_buser = '0; m_bvalid = 1'b0;
        m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_ruser = '0; m_rvalid = 1'b0;

        // Reset state.
        repeat (3) tick();
        areset = 1'b0;
        settle();
        check("rst_wr_state", dbg_wr_state, WR_IDLE);
        check("rst_rd_state", dbg_rd_state, RD_IDLE);
        check("rst_wcnt", dbg_wcnt, 0);
        check("rst_rcnt", dbg_rcnt, 0);
        check("rst_bvalid", s_bvalid, 0);
        check("rst_rvalid", s_rvalid, 0);
        check("rst_busy", {wr_busy, rd_busy}, 0);

        // In-range write at BASE, 4 beats, OKAY passed back.
        tick();
        drive_aw(32'h8000_0000, 8'd3, 5'd3);
        settle();
        check("t1_m_awvalid", m_awvalid, 1);
        check("t1_m_awaddr", m_awaddr, 64'h8000_0000);
        check("t1_m_awlen", m_awlen, 3);
        check("t1_s_awready", s_awready, 1);
        tick();
        s_awvalid = 1'b0;
        settle();
        check("t1_wcnt_1", dbg_wcnt, 1);
        check("t1_wr_busy", wr_busy, 1);
        for (int i = 0; i < 4; i++) begin
            s_wvalid = 1'b1; s_wdata = 64'hA500 + 64'(i); s_wlast = (i == 3);
            settle();
            check("t1_m_wvalid", m_wvalid, 1);
            check("t1_m_wdata", m_wdata, 64'hA500 + 64'(i));
            check("t1_m_wlast", m_wlast, (i == 3));
            tick();
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        m_bvalid = 1'b1; m_bid = 5'd3; m_bresp = RESP_OKAY; s_bready = 1'b1;
        settle();
        check("t1_s_bvalid", s_bvalid, 1);
        check("t1_s_bid", s_bid, 3);
        check("t1_s_bresp", s_bresp, RESP_OKAY);
        check("t1_m_bready", m_bready, 1);
        tick();
        m_bvalid = 1'b0;
        settle();
        check("t1_wcnt_0", dbg_wcnt, 0);
        check("t1_wr_idle", wr_busy, 0);

        // Out-of-range write just below BASE: absorbed, local DECERR.
        drive_aw(32'h7FFF_FFF0, 8'd1, 5'd5);
        settle();
        check("t2_m_awvalid", m_awvalid, 0);
        check("t2_s_awready", s_awready, 1);
        tick();
        s_awvalid = 1'b0;
        s_bready = 1'b0;
        settle();
        check("t2_state_drain", dbg_wr_state, WR_DRAIN);
        for (int i = 0; i < 2; i++) begin
            s_wvalid = 1'b1; s_wdata = 64'hDEAD; s_wlast = (i == 1);
            settle();
            check("t2_s_wready", s_wready, 1);
            check("t2_m_wvalid", m_wvalid, 0);
            check("t2_bvalid_early", s_bvalid, 0);
            tick();
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        settle();
        check("t2_bvalid", s_bvalid, 1);
        check("t2_bresp", s_bresp, RESP_DECERR);
        check("t2_bid", s_bid, 5);
        check("t2_buser", s_buser, 0);
        tick();
        settle();
        check("t2_bvalid_hold", s_bvalid, 1);
        check("t2_bid_hold", s_bid, 5);
        s_bready = 1'b1;
        tick();
        settle();
        check("t2_bvalid_done", s_bvalid, 0);
        check("t2_state_idle", dbg_wr_state, WR_IDLE);

        // Out-of-range read at BASE+SIZE, rready toggled: 4 DECERR beats.
        drive_ar(32'hC000_0000, 8'd3, 5'd9);
        settle();
        check("t3_m_arvalid", m_arvalid, 0);
        check("t3_s_arready", s_arready, 1);
        tick();
        s_arvalid = 1'b0;
        exp_q = {1'b0, 1'b0, 1'b0, 1'b1};
        beats = 0;
        for (int cyc = 0; cyc < 24 && beats < 4; cyc++) begin
            s_rready = cyc[0];
            settle();
            check("t3_rvalid", s_rvalid, 1);
            check("t3_rdata", s_rdata, 0);
            check("t3_rresp", s_rresp, RESP_DECERR);
            check("t3_rid", s_rid, 9);
            check("t3_rlast", s_rlast, exp_q[0]);
            check("t3_m_rready", m_rready, 0);
            if (s_rready) begin
                void'(exp_q.pop_front());
                beats++;
            end
            tick();
        end
        s_rready = 1'b0;
        settle();
        check("t3_beats", beats, 4);
        check("t3_rvalid_done", s_rvalid, 0);
        check("t3_rd_busy", rd_busy, 0);

        // Out-of-range AW waits for an outstanding in-range write to complete.
        tick();
        drive_aw(32'h8000_1000, 8'd0, 5'd1);
        tick();
        s_awvalid = 1'b0;
        s_wvalid = 1'b1; s_wlast = 1'b1;
        tick();
        s_wvalid = 1'b0; s_wlast = 1'b0;
        drive_aw(32'h0000_0100, 8'd0, 5'd2);
        settle();
        check("t4_awready_blocked", s_awready, 0);
        check("t4_m_awvalid", m_awvalid, 0);
        tick();
        settle();
        check("t4_awready_still", s_awready, 0);
        m_bvalid = 1'b1; m_bid = 5'd1; m_bresp = RESP_OKAY; s_bready = 1'b1;
        settle();
        check("t4_awready_on_b", s_awready, 0);
        check("t4_s_bid", s_bid, 1);
        tick();
        m_bvalid = 1'b0;
        settle();
        check("t4_awready_after_b", s_awready, 1);
        tick();
        s_awvalid = 1'b0;
        s_wvalid = 1'b1; s_wlast = 1'b1;
        settle();
        check("t4_state_drain", dbg_wr_state, WR_DRAIN);
        tick();
        s_wvalid = 1'b0; s_wlast = 1'b0;
        settle();
        check("t4_bid", s_bid, 2);
        check("t4_bresp", s_bresp, RESP_DECERR);
        tick();

        // Two in-range reads fill the read counter (max 2); third AR stalls.
        drive_ar(32'h8000_0000, 8'd0, 5'd1);
        tick();
        drive_ar(32'h8000_0040, 8'd0, 5'd2);
        tick();
        drive_ar(32'hBFFF_FFFF, 8'd0, 5'd3);
        settle();
        check("t5_rcnt_full", dbg_rcnt, 2);
        check("t5_m_arvalid_stall", m_arvalid, 0);
        check("t5_s_arready_stall", s_arready, 0);
        tick();
        m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = 5'd1; m_rdata = 64'h1234; s_rready = 1'b1;
        settle();
        check("t5_s_rvalid", s_rvalid, 1);
        check("t5_s_rid", s_rid, 1);
        check("t5_s_rdata", s_rdata, 64'h1234);
        check("t5_arready_on_r", s_arready, 0);
        tick();
        m_rvalid = 1'b0;
        settle();
        check("t5_arready_after", s_arready, 1);
        check("t5_m_arvalid", m_arvalid, 1);
        check("t5_m_araddr", m_araddr, 64'hBFFF_FFFF);
        tick();
        s_arvalid = 1'b0;
        m_rvalid = 1'b1; m_rid = 5'd2;
        tick();
        m_rid = 5'd3;
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0;
        settle();
        check("t5_rcnt_0", dbg_rcnt, 0);

        // Reset during the second beat of a local read at BASE-1.
        s_rready = 1'b1;
        drive_ar(32'h7FFF_FFFF, 8'd3, 5'd4);
        settle();
        check("t6_s_arready", s_arready, 1);
        tick();
        s_arvalid = 1'b0;
        settle();
        check("t6_beat1_last", s_rlast, 0);
        tick();
        areset = 1'b1;
        settle();
        check("t6_rvalid_beat2", s_rvalid, 1);
        check("t6_rid_beat2", s_rid, 4);
        tick();
        areset = 1'b0;
        drive_ar(32'h7FFF_FFFF, 8'd0, 5'd6);
        settle();
        check("t6_rvalid_after_rst", s_rvalid, 0);
        check("t6_state_idle", dbg_rd_state, RD_IDLE);
        check("t6_rcnt", dbg_rcnt, 0);
        check("t6_arready_fresh", s_arready, 1);
        tick();
        s_arvalid = 1'b0;
        settle();
        check("t6_fresh_rvalid", s_rvalid, 1);
        check("t6_fresh_rid", s_rid, 6);
        check("t6_fresh_rlast", s_rlast, 1);
        tick();
        settle();
        check("t6_rd_busy", rd_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
